// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the memory slave's data-phase states
package ahb_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;
    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;
endpackage

// File: rtl/ahb_lite_mem_slave_p_if.sv
// ahb_lite_mem_slave_p_if: AHB-Lite slave-side bus bundle
// master drives HSEL/HADDR/HWRITE/HSIZE/HTRANS/HBURST/HREADY/HWDATA, slave drives HREADYOUT/HRESP/HRDATA
interface ahb_lite_mem_slave_p_if #(parameter int DATA_W = 32);
    logic              HSEL;
    logic [31:0]       HADDR;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [1:0]        HTRANS;
    logic [2:0]        HBURST;
    logic              HREADY;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADYOUT;
    logic              HRESP;
    logic [DATA_W-1:0] HRDATA;
    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );
    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_byte_strobe_gen.sv
// ahb_byte_strobe_gen: lane-enable vector for a transfer of 2^size bytes starting at lane offset
// size: HSIZE code, offset: low address bits, strb: one enable per byte lane
module ahb_byte_strobe_gen #(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB)
) (
    input  logic [2:0]    size,
    input  logic [LB-1:0] offset,
    output logic [NB-1:0] strb
);
    always_comb begin
        strb = '0;
        for (int b = 0; b < NB; b++)
            strb[b] = (b >= int'(offset)) && (b < int'(offset) + (1 << size));
    end
endmodule

// File: rtl/ahb_lite_mem_slave_p.sv
// ahb_lite_mem_slave_p: AHB-Lite memory slave with byte lanes, wait states and two-cycle ERROR
// HCLK/HRESET: clock and synchronous active-high reset, bus: slave modport of the AHB-Lite bundle
module ahb_lite_mem_slave_p
    import ahb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_lite_mem_slave_p_if.slave bus
);
    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(DEPTH) * 33'(NB);
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic              active_q, active_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NB-1:0]     strb;
    logic [IW-1:0]     idx;
    logic              accept, legal, we, unused_ok;
    assign idx    = addr_q[LB +: IW];
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal  = (bus.HSIZE <= 3'(LB))
                 && ((bus.HADDR & ((32'd1 << bus.HSIZE) - 32'd1)) == 32'd0)
                 && ({1'b0, bus.HADDR} < LIMIT);
    // active_q marks a legal data phase; it ends on the cycle HREADYOUT is high
    assign we         = active_q & write_q & hreadyout_q & ~HRESET;
    assign unused_ok  = ^{bus.HBURST, bus.HTRANS[0], addr_q[31:LB+IW]};
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = (active_q & ~write_q) ? mem[idx] : '0;
    ahb_byte_strobe_gen #(.DATA_W(DATA_W)) u_strb (
        .size   (size_q),
        .offset (addr_q[LB-1:0]),
        .strb   (strb)
    );
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        size_d      = size_q;
        active_d    = active_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        if (state_q == ST_WAIT) begin
            cnt_d       = cnt_q - 3'd1;
            state_d     = (cnt_q == 3'd1) ? ST_IDLE : ST_WAIT;
            hreadyout_d = (cnt_q == 3'd1);
        end else if (state_q == ST_ERR1) begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
        end else if (accept) begin
            addr_d      = bus.HADDR;
            write_d     = bus.HWRITE;
            size_d      = bus.HSIZE;
            active_d    = legal;
            cnt_d       = 3'(WAIT_STATES);
            state_d     = !legal ? ST_ERR1 : (WAIT_STATES > 0 ? ST_WAIT : ST_IDLE);
            hreadyout_d = legal && (WAIT_STATES == 0);
            hresp_d     = legal ? HRESP_OKAY : HRESP_ERROR;
        end else begin
            state_d     = ST_IDLE;
            active_d    = 1'b0;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            active_q    <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            active_q    <= active_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end
    always_ff @(posedge HCLK) begin
        if (we)
            for (int b = 0; b < NB; b++)
                if (strb[b]) mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_lite_mem_slave_p.sv
// tb_ahb_lite_mem_slave_p: scoreboard bench driving a zero-wait and a three-wait slave instance
module tb_ahb_lite_mem_slave_p;
    import ahb_pkg::*;
    typedef struct {
        bit          rd;
        bit          err;
        int          waits;
        logic [31:0] data;
    } item_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;
    ahb_lite_mem_slave_p_if #(.DATA_W(32)) b0 ();
    ahb_lite_mem_slave_p_if #(.DATA_W(32)) b3 ();
    logic        sel = 1'b0;
    logic        m_hsel = 1'b0, m_write = 1'b0;
    logic [1:0]  m_trans = HTRANS_IDLE;
    logic [2:0]  m_size = 3'd2, m_burst = 3'd0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    assign b0.HSEL = m_hsel & ~sel;
    assign b3.HSEL = m_hsel & sel;
    assign b0.HADDR = m_addr;    assign b3.HADDR = m_addr;
    assign b0.HWRITE = m_write;  assign b3.HWRITE = m_write;
    assign b0.HSIZE = m_size;    assign b3.HSIZE = m_size;
    assign b0.HTRANS = m_trans;  assign b3.HTRANS = m_trans;
    assign b0.HBURST = m_burst;  assign b3.HBURST = m_burst;
    assign b0.HWDATA = m_wdata;  assign b3.HWDATA = m_wdata;
    assign b0.HREADY = b0.HREADYOUT;
    assign b3.HREADY = b3.HREADYOUT;
    ahb_lite_mem_slave_p #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .HCLK(clk), .HRESET(rst), .bus(b0));
    ahb_lite_mem_slave_p #(.DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u3 (
        .HCLK(clk), .HRESET(rst), .bus(b3));
    logic        o_rdy, o_resp;
    logic [31:0] o_rdata;
    assign o_rdy   = sel ? b3.HREADYOUT : b0.HREADYOUT;
    assign o_resp  = sel ? b3.HRESP : b0.HRESP;
    assign o_rdata = sel ? b3.HRDATA : b0.HRDATA;
    logic [31:0] sh [2][256];
    item_t q[$];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // one address phase; returns just after the edge that accepts it, then drives its write data
    task automatic ap(input bit hs, input logic [1:0] tr, input bit wr,
                      input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        item_t it;
        bit legal, r;
        int w;
        m_hsel = hs; m_trans = tr; m_write = wr; m_addr = a; m_size = sz;
        if (hs && tr[1]) begin
            legal = (sz <= 3'd2) && ((a & ((32'd1 << sz) - 32'd1)) == 0) && (a < 32'd1024);
            it.rd = !wr;
            it.err = !legal;
            it.waits = legal ? (sel ? 3 : 0) : 1;
            if (legal && wr)
                for (int k = 0; k < (1 << sz); k++)
                    sh[sel][a[9:2]][8*(int'(a[1:0])+k) +: 8] = wd[8*(int'(a[1:0])+k) +: 8];
            it.data = sh[sel][a[9:2]];
            q.push_back(it);
        end
        w = 0;
        do begin
            @(negedge clk);
            r = o_rdy;
            @(posedge clk);
            #1;
            w++;
        end while (!r && w < 20);
        chk("accept_timeout", 32'(r), 32'd1);
        m_wdata = wd;
    endtask
    task automatic idle();
        ap(1'b1, HTRANS_IDLE, 1'b0, 32'h0, 3'd2, 32'h0);
    endtask
    // monitor: pops the scoreboard at each data-phase completion
    logic dp = 1'b0, acc_n = 1'b0, rdy_n = 1'b0;
    int wc = 0;
    item_t mi;
    always @(negedge clk) begin
        acc_n = m_hsel & m_trans[1] & o_rdy;
        rdy_n = o_rdy;
        if (rst) wc = 0;
        else if (!dp) chk("idle_bus", {29'd0, o_rdy, o_resp, |o_rdata}, 32'b100);
        else if (q.size() == 0) chk("no_pending", 32'd1, 32'd0);
        else if (!o_rdy) begin
            wc++;
            chk("wait_resp", 32'(o_resp), 32'(q[0].err));
        end else begin
            mi = q.pop_front();
            chk("done_resp", 32'(o_resp), 32'(mi.err));
            chk("done_rdata", o_rdata, (mi.rd && !mi.err) ? mi.data : 32'h0);
            chk("done_waits", 32'(wc), 32'(mi.waits));
            wc = 0;
        end
    end
    always @(posedge clk) begin
        if (rst) dp <= 1'b0;
        else if (rdy_n) dp <= acc_n;
    end
    int t0, t1;
    logic [31:0] old80;
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy0", 32'(b0.HREADYOUT), 32'd1);
        chk("rst_resp0", 32'(b0.HRESP), 32'd0);
        chk("rst_rdata0", b0.HRDATA, 32'h0);
        chk("rst_rdy3", 32'(b3.HREADYOUT), 32'd1);
        chk("rst_resp3", 32'(b3.HRESP), 32'd0);
        rst = 1'b0;
        // write then read the same word back-to-back
        ap(1, HTRANS_NONSEQ, 1, 32'h10, 3'd2, 32'hDEADBEEF);
        ap(1, HTRANS_NONSEQ, 0, 32'h10, 3'd2, 32'h0);
        idle();
        // byte and halfword merge into a preset word
        ap(1, HTRANS_NONSEQ, 1, 32'h20, 3'd2, 32'h11223344);
        ap(1, HTRANS_NONSEQ, 1, 32'h21, 3'd0, 32'h0000AA00);
        ap(1, HTRANS_NONSEQ, 1, 32'h22, 3'd1, 32'hBBCC0000);
        ap(1, HTRANS_NONSEQ, 0, 32'h20, 3'd2, 32'h0);
        idle();
        chk("merge_model", sh[0][8], 32'hBBCCAA44);
        // illegal accesses: misaligned, oversize, out of range
        ap(1, HTRANS_NONSEQ, 1, 32'h0, 3'd2, 32'h01020304);
        ap(1, HTRANS_NONSEQ, 0, 32'h2, 3'd2, 32'h0);
        ap(1, HTRANS_NONSEQ, 1, 32'h0, 3'd3, 32'hFFFFFFFF);
        ap(1, HTRANS_NONSEQ, 1, 32'h400, 3'd2, 32'hFFFFFFFF);
        ap(1, HTRANS_NONSEQ, 0, 32'h0, 3'd2, 32'h0);
        idle();
        // BUSY and IDLE inside a burst, then a NONSEQ with HSEL low
        ap(1, HTRANS_NONSEQ, 1, 32'h3C, 3'd2, 32'h5A5A5A5A);
        ap(1, HTRANS_NONSEQ, 1, 32'h30, 3'd2, 32'hA0A0A0A0);
        ap(1, HTRANS_BUSY, 1, 32'h34, 3'd2, 32'hEEEEEEEE);
        ap(1, HTRANS_SEQ, 1, 32'h34, 3'd2, 32'hB1B1B1B1);
        ap(1, HTRANS_IDLE, 1, 32'h38, 3'd2, 32'hEEEEEEEE);
        ap(1, HTRANS_NONSEQ, 1, 32'h38, 3'd2, 32'hC2C2C2C2);
        ap(0, HTRANS_NONSEQ, 1, 32'h3C, 3'd2, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) ap(1, HTRANS_NONSEQ, 0, 32'h30 + 32'(4*i), 3'd2, 32'h0);
        idle();
        // three-wait instance: INCR4 write burst then readback
        sel = 1'b1;
        m_burst = 3'b011;
        ap(1, HTRANS_NONSEQ, 1, 32'h40, 3'd2, 32'h40404040);
        t0 = cyc;
        ap(1, HTRANS_SEQ, 1, 32'h44, 3'd2, 32'h44444444);
        ap(1, HTRANS_SEQ, 1, 32'h48, 3'd2, 32'h48484848);
        ap(1, HTRANS_SEQ, 1, 32'h4C, 3'd2, 32'h4C4C4C4C);
        idle();
        t1 = cyc;
        chk("burst_cycles", 32'(t1 - t0), 32'd16);
        m_burst = 3'b000;
        for (int i = 0; i < 4; i++) ap(1, HTRANS_NONSEQ, 0, 32'h40 + 32'(4*i), 3'd2, 32'h0);
        idle();
        // reset during the wait states of a write drops the write
        ap(1, HTRANS_NONSEQ, 1, 32'h80, 3'd2, 32'h600DF00D);
        idle();
        old80 = sh[1][32];
        ap(1, HTRANS_NONSEQ, 1, 32'h80, 3'd2, 32'hCAFEF00D);
        m_trans = HTRANS_IDLE;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rdy", 32'(o_rdy), 32'd1);
        chk("midrst_resp", 32'(o_resp), 32'd0);
        chk("midrst_rdata", o_rdata, 32'h0);
        q.delete();
        sh[1][32] = old80;
        rst = 1'b0;
        ap(1, HTRANS_NONSEQ, 0, 32'h80, 3'd2, 32'h0);
        idle();
        repeat (2) idle();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_mem_slave_p.md
# ahb_lite_mem_slave_p

Parametrised AHB-Lite memory slave, successor to the fixed 8-bit-array memory slave. Adds a proper address/data-phase pipeline, configurable data-bus width and depth, HSIZE-driven byte-lane writes, programmable wait states, and a two-cycle ERROR response for illegal accesses. Sits behind the address decoder and read-data/response mux on the AHB-Lite bus.

## Interface
- DATA_W, 32: bus and memory word width in bits; 32 or 64.
- DEPTH, 256: memory words; power of two.
- WAIT_STATES, 0: wait cycles inserted into every legal NONSEQ/SEQ data phase; 0..7.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, bytes = 2^HSIZE.
- HTRANS  in  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- HBURST  in  3  accepted, not interpreted; each beat carries its own address.
- HREADY  in  1  bus-level ready from the mux.
- HWDATA  in  DATA_W  write data, valid in data phase.
- HREADYOUT  out  1  slave ready; reset 1.
- HRESP  out  1  0 OKAY, 1 ERROR; reset 0.
- HRDATA  out  DATA_W  read data; reset 0.

## Operation
- Address phase accepted on a rising edge with HSEL & HREADY & HTRANS[1]. Registers addr_q, write_q, size_q, and a data-phase state.
- IDLE/BUSY, or HSEL=0: no data phase; HREADYOUT=1, HRESP=0 the next cycle.
- Legality checked at acceptance. ERROR when any of: HSIZE > log2(DATA_W/8); HADDR not aligned to 2^HSIZE; HADDR >= DEPTH*DATA_W/8.
- Legal transfer: word index = addr_q >> log2(DATA_W/8); lane offset = low address bits. Little-endian: byte k of the transfer sits on lane (offset+k).
- Write: only the 2^size_q lanes starting at offset are updated, from the matching HWDATA lanes, on the edge ending the data phase (HREADYOUT=1). Other lanes are unchanged.
- Read: HRDATA = full memory word at the word index, combinationally from the array, during the data phase. It is valid whenever HREADYOUT=1. Lanes outside the transfer are don't-care for the master but must be the true memory contents. HRDATA = 0 outside read data phases.
- Illegal transfers never modify memory.
- States:
  - IDLE: no data phase pending.
  - WAIT: counting down the wait states; HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Legal accept: to WAIT if WAIT_STATES>0, otherwise completes in the next cycle from IDLE.
  - Illegal accept: ERR1, then ERR2, then back to IDLE, or directly into the next transfer if a new address phase is accepted on the ERR2 edge.
- Memory contents are not cleared by reset.

## Timing
- Zero wait: a transfer accepted at edge N completes at edge N+1. Back-to-back NONSEQ/SEQ beats give 1 beat per cycle.
- WAIT_STATES=W: HREADYOUT is low for exactly W cycles after acceptance and high on cycle W+1. The data phase ends at edge N+W+1.
- ERROR: always 2 cycles, regardless of WAIT_STATES.
- Pipelining: the next address phase is sampled only on the edge where HREADY=1, which is the same edge that ends the current data phase. While HREADYOUT=0, new HTRANS/HADDR values are ignored.
- Write followed by read of the same word: the read returns the new data with no hazard. The write commits at the edge that starts the read's data phase, and the read is asynchronous from the array.
- Reset asserted mid-transfer: at the next edge the state goes to IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, and any pending write is dropped.
- HSEL=0 while the slave is mid-WAIT: the current data phase still completes; HSEL is only qualified at acceptance.

## Structure
- Shared package ahb_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP codes (OKAY, ERROR).
  - HSIZE encodings (BYTE, HALF, WORD, DWORD).
  - State enum (IDLE, WAIT, ERR1, ERR2).
- One sub-module, ahb_byte_strobe_gen: combinational; maps (size, low address bits) to a DATA_W/8-bit lane-enable vector. Used for write masking.
- Memory: a DEPTH x DATA_W array with per-lane write enables, in the top level.

## Test plan
- DATA_W=32, W=0: NONSEQ write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Required: HRDATA=0xDEADBEEF one cycle after the read is accepted, HREADYOUT high throughout.
- Byte/half merge: word at 0x20 preset to 0x11223344. Write byte 0xAA to 0x21, then half 0xBBCC to 0x22. Required: reading 0x20 returns 0xBBCCAA44.
- W=3: INCR4 write burst of 4 words. Required: HREADYOUT low for 3 cycles before each beat completes, 16 cycles total, all 4 words correct on readback.
- Errors: misaligned word read at 0x02, then HSIZE=3 on DATA_W=32, then address DEPTH*4. Required for each: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), and memory is unchanged.
- BUSY and IDLE inserted mid-burst, and HSEL=0 with NONSEQ. Required: OKAY with zero wait, no memory change.
- HRESET pulsed during WAIT of a write. Required: next cycle HREADYOUT=1, HRESP=0, HRDATA=0; target word keeps its old value.
